// File: rtl/nx_axi4s_slot_bridge.sv
// Bidirectional AXI4-stream <-> Nexus bridge: packs several messages per beat into
// flagged slots, unpacks inbound beats in slot order, and flushes partial beats on idle.
module nx_axi4s_slot_bridge #(
    parameter int AXI4_DATA_WIDTH = 128,
    parameter int MSG_WIDTH       = 31,
    parameter int FLUSH_CYCLES    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [AXI4_DATA_WIDTH-1:0] ib_axi4s_tdata_i,
    input  logic                       ib_axi4s_tlast_i,
    input  logic                       ib_axi4s_tvalid_i,
    output logic                       ib_axi4s_tready_o,
    output logic [MSG_WIDTH-1:0]       ob_nx_data_o,
    output logic                       ob_nx_valid_o,
    input  logic                       ob_nx_ready_i,
    input  logic [MSG_WIDTH-1:0]       ib_nx_data_i,
    input  logic                       ib_nx_valid_i,
    output logic                       ib_nx_ready_o,
    output logic [AXI4_DATA_WIDTH-1:0] ob_axi4s_tdata_o,
    output logic                       ob_axi4s_tlast_o,
    output logic                       ob_axi4s_tvalid_o,
    input  logic                       ob_axi4s_tready_i,
    output logic                       idle_o
);
    localparam int SLOT_W = MSG_WIDTH + 1;
    localparam int SLOTS  = AXI4_DATA_WIDTH / SLOT_W;
    localparam int CNT_W  = $clog2(SLOTS + 1);
    localparam int TMR_W  = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FLUSH_CYCLES);

    logic unused_tlast;
    assign unused_tlast = ib_axi4s_tlast_i;

    // ---------------- unpack ----------------
    logic [SLOTS-1:0][MSG_WIDTH-1:0] ub_msg_q;
    logic [SLOTS-1:0][MSG_WIDTH-1:0] ib_msgs;
    logic [SLOTS-1:0]                ub_mask_q;
    logic [SLOTS-1:0]                ib_flags;
    logic [MSG_WIDTH-1:0]            ub_head;
    logic                            ib_axi_hs;
    logic                            ob_nx_hs;

    always_comb begin
        for (int k = 0; k < SLOTS; k++) begin
            ib_flags[k] = ib_axi4s_tdata_i[k*SLOT_W + MSG_WIDTH];
            ib_msgs[k]  = ib_axi4s_tdata_i[k*SLOT_W +: MSG_WIDTH];
        end
    end

    // descending scan so the lowest pending slot wins
    always_comb begin
        ub_head = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (ub_mask_q[k]) ub_head = ub_msg_q[k];
        end
    end

    assign ib_axi4s_tready_o = ~rst_i & (ub_mask_q == '0);
    assign ob_nx_valid_o     = |ub_mask_q;
    assign ob_nx_data_o      = ub_head;
    assign ib_axi_hs         = ib_axi4s_tvalid_i & ib_axi4s_tready_o;
    assign ob_nx_hs          = ob_nx_valid_o & ob_nx_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ub_msg_q  <= '0;
            ub_mask_q <= '0;
        end else if (ib_axi_hs) begin
            ub_msg_q  <= ib_msgs;
            ub_mask_q <= ib_flags;
        end else if (ob_nx_hs) begin
            ub_mask_q <= ub_mask_q & (ub_mask_q - SLOTS'(1));
        end
    end

    // ---------------- pack ----------------
    // tmr_q counts down from FLUSH_CYCLES; zero with a non-empty accumulator means flush.
    logic [AXI4_DATA_WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [TMR_W-1:0]           tmr_q;
    logic [AXI4_DATA_WIDTH-1:0] ob_tdata_q;
    logic                       ob_tlast_q;
    logic                       ob_tvalid_q;
    logic                       acc_full;
    logic                       flush_pend;
    logic                       out_free;
    logic                       xfer;
    logic                       ib_nx_hs;

    assign acc_full      = (cnt_q == CNT_FULL);
    assign flush_pend    = (FLUSH_CYCLES != 0) && (cnt_q != '0) && (tmr_q == '0);
    assign ib_nx_ready_o = ~rst_i & (cnt_q < CNT_FULL) & ~flush_pend;
    assign ib_nx_hs      = ib_nx_valid_i & ib_nx_ready_o;
    assign out_free      = ~ob_tvalid_q | ob_axi4s_tready_i;
    assign xfer          = out_free & (acc_full | flush_pend);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
            tmr_q <= TMR_LOAD;
        end else if (xfer) begin
            acc_q <= '0;
            cnt_q <= '0;
            tmr_q <= TMR_LOAD;
        end else if (ib_nx_hs) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (cnt_q == CNT_W'(k)) acc_q[k*SLOT_W +: SLOT_W] <= {1'b1, ib_nx_data_i};
            end
            cnt_q <= cnt_q + CNT_W'(1);
            tmr_q <= TMR_LOAD;
        end else if ((cnt_q != '0) && (tmr_q != '0)) begin
            tmr_q <= tmr_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ob_tdata_q  <= '0;
            ob_tlast_q  <= 1'b0;
            ob_tvalid_q <= 1'b0;
        end else if (xfer) begin
            ob_tdata_q  <= acc_q;
            ob_tlast_q  <= flush_pend & ~acc_full;
            ob_tvalid_q <= 1'b1;
        end else if (out_free) begin
            ob_tvalid_q <= 1'b0;
        end
    end

    assign ob_axi4s_tdata_o  = ob_tdata_q;
    assign ob_axi4s_tlast_o  = ob_tlast_q;
    assign ob_axi4s_tvalid_o = ob_tvalid_q;
    assign idle_o            = (ub_mask_q == '0) & (cnt_q == '0) & ~ob_tvalid_q;

endmodule
